// File: rtl/rv32i_mc_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory states
// and drives every datapath select, load enable and memory handshake.
module rv32i_mc_control #(
  parameter int NUM_STATE_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_en,
  input  logic [1:0] mar_lsb,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_data_out,
  output logic [1:0] pcmux_sel,
  output logic       marmux_sel,
  output logic       cmpmux_sel,
  output logic       alumux1_sel,
  output logic [2:0] alumux2_sel,
  output logic [3:0] regfilemux_sel,
  output logic [2:0] aluop,
  output logic [2:0] cmpop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SRA = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b101;

  // IMM and REG share one execute state (outputs split on opcode); ST2 and
  // ILLEGAL share ADV_PC since both only advance the PC.
  typedef enum logic [NUM_STATE_BITS-1:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_ALU, S_LUI, S_AUIPC, S_BR,
    S_JAL, S_JALR, S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ADV_PC
  } state_e;

  state_e state_q, state_d;
  logic   is_imm;
  logic   unused_funct7;

  assign is_imm        = (opcode == OP_IMM);
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH1;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    pcmux_sel       = 2'b00;
    marmux_sel      = 1'b0;
    cmpmux_sel      = 1'b0;
    alumux1_sel     = 1'b0;
    alumux2_sel     = 3'b000;
    regfilemux_sel  = 4'd0;
    aluop           = funct3;
    cmpop           = funct3;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'b1111;
    unique case (state_q)
      S_FETCH1: begin
        load_mar = 1'b1;
        state_d  = S_FETCH2;
      end
      S_FETCH2: begin
        mem_read = 1'b1;
        load_mdr = 1'b1;
        if (mem_resp) state_d = S_FETCH3;
      end
      S_FETCH3: begin
        load_ir = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_LUI:             state_d = S_LUI;
          OP_AUIPC:           state_d = S_AUIPC;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_BR:              state_d = S_BR;
          OP_LOAD, OP_STORE:  state_d = S_CALC_ADDR;
          OP_IMM, OP_REG:     state_d = S_ALU;
          default:            state_d = S_ADV_PC;
        endcase
      end
      S_ALU: begin
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        alumux2_sel  = is_imm ? 3'b000 : 3'b101;
        unique case (funct3)
          3'b010: begin
            cmpmux_sel     = is_imm;
            cmpop          = 3'b100;
            regfilemux_sel = 4'd1;
          end
          3'b011: begin
            cmpmux_sel     = is_imm;
            cmpop          = 3'b110;
            regfilemux_sel = 4'd1;
          end
          3'b101:  aluop = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b000:  if (!is_imm && funct7[5]) aluop = ALU_SUB;
          default: ;
        endcase
        state_d = S_FETCH1;
      end
      S_LUI: begin
        regfilemux_sel = 4'd2;
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
        state_d        = S_FETCH1;
      end
      S_AUIPC: begin
        alumux1_sel  = 1'b1;
        alumux2_sel  = 3'b001;
        aluop        = ALU_ADD;
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        state_d      = S_FETCH1;
      end
      S_BR: begin
        alumux1_sel = 1'b1;
        alumux2_sel = 3'b010;
        aluop       = ALU_ADD;
        load_pc     = 1'b1;
        pcmux_sel   = br_en ? 2'b01 : 2'b00;
        state_d     = S_FETCH1;
      end
      S_JAL, S_JALR: begin
        regfilemux_sel = 4'd4;
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
        aluop          = ALU_ADD;
        if (state_q == S_JAL) begin
          alumux1_sel = 1'b1;
          alumux2_sel = 3'b100;
          pcmux_sel   = 2'b01;
        end else begin
          pcmux_sel   = 2'b10;
        end
        state_d = S_FETCH1;
      end
      S_CALC_ADDR: begin
        aluop      = ALU_ADD;
        marmux_sel = 1'b1;
        load_mar   = 1'b1;
        if (opcode == OP_LOAD) begin
          state_d = S_LD1;
        end else begin
          alumux2_sel   = 3'b011;
          load_data_out = 1'b1;
          state_d       = S_ST1;
        end
      end
      S_LD1: begin
        mem_read = 1'b1;
        load_mdr = 1'b1;
        if (mem_resp) state_d = S_LD2;
      end
      S_LD2: begin
        unique case (funct3)
          3'b000:  regfilemux_sel = 4'd5;
          3'b001:  regfilemux_sel = 4'd7;
          3'b100:  regfilemux_sel = 4'd6;
          3'b101:  regfilemux_sel = 4'd8;
          default: regfilemux_sel = 4'd3;
        endcase
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        state_d      = S_FETCH1;
      end
      S_ST1: begin
        mem_write = 1'b1;
        unique case (funct3)
          3'b000:  mem_byte_enable = 4'b0001 << mar_lsb;
          3'b001:  mem_byte_enable = 4'b0011 << {mar_lsb[1], 1'b0};
          default: mem_byte_enable = 4'b1111;
        endcase
        if (mem_resp) state_d = S_ADV_PC;
      end
      S_ADV_PC: begin
        load_pc = 1'b1;
        state_d = S_FETCH1;
      end
      default: state_d = S_FETCH1;
    endcase
  end

endmodule
